// File: rtl/rally_pkg.sv
// Shared rally-game types: level codes, round_tracker state encoding and sizing constants.
package rally_pkg;

   typedef enum logic [1:0] {
      LVL_NONE = 2'd0,
      LVL_1    = 2'd1,
      LVL_2    = 2'd2,
      LVL_3    = 2'd3
   } level_e;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StRun  = 2'd1,
      StDone = 2'd2
   } rt_state_e;

   localparam int unsigned MAX_FLAGS = 8;
   localparam int unsigned SECS_W    = 8;

endpackage

// File: rtl/round_tracker_if.sv
// Round-tracker bus: game/collision controls in, sticky round results and display values out.
interface round_tracker_if;
   import rally_pkg::*;

   logic                 game_active;
   logic [1:0]           level_id;
   logic                 flag_hit;
   logic [2:0]           flag_idx;
   logic                 time_out;
   logic                 all_flags;
   logic [SECS_W-1:0]    secs_left;
   logic [MAX_FLAGS-1:0] flags_mask;
   logic [3:0]           flags_count;
   logic                 sec_tick;

   modport master (
      output game_active, level_id, flag_hit, flag_idx,
      input  time_out, all_flags, secs_left, flags_mask, flags_count, sec_tick
   );

   modport slave (
      input  game_active, level_id, flag_hit, flag_idx,
      output time_out, all_flags, secs_left, flags_mask, flags_count, sec_tick
   );

endinterface

// File: rtl/sec_prescaler.sv
// Free-running 0..CLK_HZ-1 counter; tick is high on the cycle the count wraps.
module sec_prescaler #(
   parameter int unsigned CLK_HZ = 50_000_000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic tick
);

   localparam int unsigned CntW = (CLK_HZ > 2) ? $clog2(CLK_HZ) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(CLK_HZ - 1);

   logic [CntW-1:0] cnt_q;

   assign tick = enable && (cnt_q == CntMax);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else if (clear) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= tick ? '0 : cnt_q + 1'b1;
      end
   end

endmodule

// File: rtl/round_tracker.sv
// Round countdown and flag bookkeeping with sticky time_out / all_flags results.
// Optional feature: define ROUND_TIME_BONUS_EN to add BONUS_SECS per newly collected flag.
module round_tracker
   import rally_pkg::*;
#(
   parameter int unsigned CLK_HZ     = 50_000_000,
   parameter int unsigned NUM_FLAGS  = 8,
   parameter int unsigned L1_SECS    = 90,
   parameter int unsigned L2_SECS    = 60,
   parameter int unsigned L3_SECS    = 45,
   parameter int unsigned BONUS_SECS = 5
) (
   input logic            clk,
   input logic            rst,
   round_tracker_if.slave bus
);

   localparam logic [3:0]           NumFlagsW = 4'(NUM_FLAGS);
   localparam logic [MAX_FLAGS-1:0] FullMask  = MAX_FLAGS'((9'd1 << NUM_FLAGS) - 9'd1);

   if (CLK_HZ < 2 || NUM_FLAGS < 1 || NUM_FLAGS > MAX_FLAGS || BONUS_SECS > 255 ||
       L1_SECS < 1 || L1_SECS > 255 || L2_SECS < 1 || L2_SECS > 255 ||
       L3_SECS < 1 || L3_SECS > 255) begin : g_bad_param
      $error("round_tracker: parameter out of range");
   end

   rt_state_e            state_q;
   logic                 ga_q;
   logic                 start;
   logic                 tick;
   logic [SECS_W-1:0]    load_secs;
   logic [MAX_FLAGS-1:0] hit_bit;
   logic [MAX_FLAGS-1:0] mask_nxt;
   logic                 mask_full;
   logic [3:0]           cnt_nxt;
   logic [SECS_W-1:0]    secs_base;
   logic [SECS_W-1:0]    secs_nxt;
`ifdef ROUND_TIME_BONUS_EN
   logic                 new_bit;
   logic [SECS_W:0]      bonus_sum;
`endif

   assign start = bus.game_active && !ga_q && (state_q != StRun);

   sec_prescaler #(
      .CLK_HZ(CLK_HZ)
   ) u_prescaler (
      .clk   (clk),
      .rst   (rst),
      .clear (start),
      .enable(state_q == StRun && bus.game_active),
      .tick  (tick)
   );

   always_comb begin
      load_secs = SECS_W'(L1_SECS);
      case (level_e'(bus.level_id))
         LVL_NONE, LVL_1: load_secs = SECS_W'(L1_SECS);
         LVL_2:           load_secs = SECS_W'(L2_SECS);
         LVL_3:           load_secs = SECS_W'(L3_SECS);
      endcase
   end

   always_comb begin
      hit_bit = '0;
      if (bus.flag_hit && ({1'b0, bus.flag_idx} < NumFlagsW)) hit_bit[bus.flag_idx] = 1'b1;
      mask_nxt  = bus.flags_mask | hit_bit;
      mask_full = (mask_nxt == FullMask);
      cnt_nxt   = '0;
      for (int i = 0; i < MAX_FLAGS; i++) cnt_nxt = cnt_nxt + {3'b0, mask_nxt[i]};
      // The final flag wins over a coincident last second: no decrement on that edge.
      secs_base = bus.secs_left;
      if (tick && !mask_full && bus.secs_left != '0) secs_base = bus.secs_left - 8'd1;
`ifdef ROUND_TIME_BONUS_EN
      new_bit   = |(hit_bit & ~bus.flags_mask);
      bonus_sum = {1'b0, secs_base} + (new_bit ? 9'(BONUS_SECS) : 9'd0);
      secs_nxt  = bonus_sum[SECS_W] ? '1 : bonus_sum[SECS_W-1:0];
`else
      secs_nxt  = secs_base;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q         <= StIdle;
         ga_q            <= 1'b0;
         bus.time_out    <= 1'b0;
         bus.all_flags   <= 1'b0;
         bus.secs_left   <= '0;
         bus.flags_mask  <= '0;
         bus.flags_count <= '0;
         bus.sec_tick    <= 1'b0;
      end else begin
         ga_q         <= bus.game_active;
         bus.sec_tick <= 1'b0;
         case (state_q)
            StIdle, StDone: begin
               if (start) begin
                  state_q         <= StRun;
                  bus.secs_left   <= load_secs;
                  bus.flags_mask  <= '0;
                  bus.flags_count <= '0;
                  bus.time_out    <= 1'b0;
                  bus.all_flags   <= 1'b0;
               end
            end
            StRun: begin
               if (!bus.game_active) begin
                  state_q <= StIdle;
               end else begin
                  bus.sec_tick    <= tick;
                  bus.flags_mask  <= mask_nxt;
                  bus.flags_count <= cnt_nxt;
                  bus.secs_left   <= secs_nxt;
                  if (mask_full) begin
                     bus.all_flags <= 1'b1;
                     state_q       <= StDone;
                  end else if (secs_nxt == '0) begin
                     bus.time_out <= 1'b1;
                     state_q      <= StDone;
                  end
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_round_tracker.sv
// Randomised scoreboard bench for round_tracker against a cycle-level round model.
module tb_round_tracker;

   localparam int unsigned ClkHz    = 10;
   localparam int unsigned NumFlags = 4;
`ifdef ROUND_TIME_BONUS_EN
   localparam int unsigned L1       = 253;
   localparam bit          BonusEn  = 1'b1;
`else
   localparam int unsigned L1       = 90;
   localparam bit          BonusEn  = 1'b0;
`endif
   localparam int unsigned L2       = 60;
   localparam int unsigned L3       = 45;
   localparam int unsigned Bonus    = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;

   round_tracker_if bus ();

   round_tracker #(
      .CLK_HZ    (ClkHz),
      .NUM_FLAGS (NumFlags),
      .L1_SECS   (L1),
      .L2_SECS   (L2),
      .L3_SECS   (L3),
      .BONUS_SECS(Bonus)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      int secs;
      int mask;
      int count;
      int to;
      int af;
      int tick;
   } exp_t;

   exp_t q[$];
   int   total = 0;
   int   bad   = 0;

   // Model: phase 0 = idle, 1 = running, 2 = finished.
   int       m_phase, m_secs, m_cyc;
   bit [7:0] m_mask;
   bit       m_prev, m_to, m_af, m_tick;

   task automatic check(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic int level_secs(input int lvl);
      if (lvl == 2) return L2;
      if (lvl == 3) return L3;
      return L1;
   endfunction

   function automatic int sat(input int x);
      return (x > 255) ? 255 : x;
   endfunction

   task automatic model_reset();
      m_phase = 0; m_secs = 0; m_cyc = 0; m_mask = '0;
      m_prev = 0; m_to = 0; m_af = 0; m_tick = 0;
   endtask

   // Drive one cycle at a negedge, predict the next posedge result, return at the next negedge.
   task automatic step(input bit ga, input int lvl, input bit hit, input int idx);
      exp_t e;
      bit   newb;
      int   add;
      bus.game_active = ga;
      bus.level_id    = 2'(lvl);
      bus.flag_hit    = hit;
      bus.flag_idx    = 3'(idx);
      m_tick = 0;
      if (m_phase != 1 && ga && !m_prev) begin
         m_phase = 1; m_secs = level_secs(lvl); m_mask = '0;
         m_to = 0; m_af = 0; m_cyc = 0;
      end else if (m_phase == 1) begin
         if (!ga) begin
            m_phase = 0;
         end else begin
            m_cyc++;
            m_tick = (m_cyc % ClkHz) == 0;
            newb = hit && idx < NumFlags && !m_mask[idx];
            if (hit && idx < NumFlags) m_mask[idx] = 1'b1;
            add = (BonusEn && newb) ? Bonus : 0;
            if (int'(m_mask) == (1 << NumFlags) - 1) begin
               m_af = 1; m_phase = 2; m_secs = sat(m_secs + add);
            end else begin
               m_secs = sat(m_secs - (m_tick ? 1 : 0) + add);
               if (m_secs == 0) begin
                  m_to = 1; m_phase = 2;
               end
            end
         end
      end
      m_prev = ga;
      e.secs = m_secs; e.mask = int'(m_mask); e.count = $countones(m_mask);
      e.to = m_to; e.af = m_af; e.tick = m_tick;
      q.push_back(e);
      @(negedge clk);
   endtask

   task automatic check_zero_outputs();
      check("rst_secs_left", int'(bus.secs_left), 0);
      check("rst_flags_mask", int'(bus.flags_mask), 0);
      check("rst_flags_count", int'(bus.flags_count), 0);
      check("rst_time_out", int'(bus.time_out), 0);
      check("rst_all_flags", int'(bus.all_flags), 0);
      check("rst_sec_tick", int'(bus.sec_tick), 0);
   endtask

   task automatic pulse_reset();
      rst = 1'b1;
      #1;
      check_zero_outputs();
      @(negedge clk);
      rst = 1'b0;
      model_reset();
   endtask

   // Monitor: every posedge with a pending prediction, compare the registered outputs.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("secs_left", int'(bus.secs_left), e.secs);
            check("flags_mask", int'(bus.flags_mask), e.mask);
            check("flags_count", int'(bus.flags_count), e.count);
            check("time_out", int'(bus.time_out), e.to);
            check("all_flags", int'(bus.all_flags), e.af);
            check("sec_tick", int'(bus.sec_tick), e.tick);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seq[5];
      bit ga;
      seq = '{0, 1, 1, 2, 3};
      bus.game_active = 1'b0; bus.level_id = 2'd0; bus.flag_hit = 1'b0; bus.flag_idx = 3'd0;
      model_reset();
      #2 rst = 1'b1;
      repeat (2) @(negedge clk);
      check_zero_outputs();
      rst = 1'b0;

      // Level 2 countdown to time_out; only out-of-range hits while running, ignored hits after.
      step(1, 2, 0, 0);
      repeat (610) step(1, $urandom_range(0, 3), $urandom_range(0, 3) == 0, $urandom_range(4, 7));
      for (int i = 0; i < 4; i++) step(1, 1, 1, i);
      repeat (3) step(0, 1, 0, 0);

      // Collect flags with a repeat; round ends on all_flags and the timer stops.
      step(1, 1, 0, 0);
      for (int i = 0; i < 5; i++) begin
         repeat ($urandom_range(0, 5)) step(1, 1, 0, 0);
         step(1, 1, 1, seq[i]);
      end
      repeat (20) step(1, 2, $urandom_range(0, 1), $urandom_range(0, 7));
      step(0, 1, 0, 0);

      // Final flag on the same edge as the last second.
      step(1, 3, 0, 0);
      for (int n = 1; n <= 450; n++) step(1, $urandom_range(0, 3), n <= 3 || n == 450, (n <= 3) ? n - 1 : 3);
      repeat (5) step(1, 3, 0, 0);
      step(0, 3, 0, 0);

      // Abort at 30 s left, restart on level 3, then reset mid-round.
      step(1, 2, 0, 0);
      step(1, 2, 1, 0);
      step(1, 2, 1, 1);
      repeat (298) step(1, 2, 0, 0);
      repeat (5) step(0, 1, 0, 0);
      step(1, 3, 0, 0);
      repeat (50) step(1, 1, 0, 0);
      pulse_reset();
      repeat (3) step(0, 0, 0, 0);

`ifdef ROUND_TIME_BONUS_EN
      step(1, 1, 0, 0);
      step(1, 1, 1, 0);
      step(1, 1, 1, 0);
      repeat (12) step(1, 1, 0, 0);
      step(0, 1, 0, 0);
`endif

      // Random play: occasional level changes, aborts, restarts and resets.
      ga = 1'b0;
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 149) == 0) ga = ~ga;
         if ($urandom_range(0, 999) == 0) pulse_reset();
         step(ga, $urandom_range(0, 3), $urandom_range(0, 5) == 0, $urandom_range(0, 7));
      end

      repeat (3) @(negedge clk);
      check("queue_drained", q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
